cmd_mux_queue: RTL and testbench
================================

# cmd_mux_queue

Single-clock, multi-channel command concentrator. NUM_CH independent sources each present a command with a four-phase req/ack handshake. An arbiter (round-robin or fixed-priority) accepts one command per cycle into a DEPTH-entry FIFO, tagged with its channel index. The FIFO drains to one downstream consumer over a req/ack transfer interface. It sits after the per-source command synchronisers and feeds the shared command executor.

## Interface
- CMD_WIDTH, 16, command width in bits
- NUM_CH, 4, number of source channels (2..16)
- DEPTH, 8, FIFO entries (power of two, >=2)
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (ch0 highest)
- CH_W = $clog2(NUM_CH), LVL_W = $clog2(DEPTH+1) (derived, not overridable)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- src_cmd  in  NUM_CH*CMD_WIDTH  channel i command in bits [i*CMD_WIDTH +: CMD_WIDTH]
- src_req  in  NUM_CH  per-channel request level
- src_ack  out  NUM_CH  per-channel acknowledge level
- dst_cmd  out  CMD_WIDTH  head-of-FIFO command
- dst_ch  out  CH_W  channel index of head entry
- dst_req  out  1  head entry valid
- dst_ack  in  1  consumer accepts head when dst_req=1
- fifo_level  out  LVL_W  current occupancy, 0..DEPTH

## Operation
- Per-channel FSM, two states:
  - IDLE: eligible when src_req[i]=1. On grant, capture src_cmd slice and channel index into FIFO, go to ACK.
  - ACK: src_ack[i]=1. Stay until src_req[i]=0, then go to IDLE (src_ack[i]=0 next cycle).
- The channel re-arbitrates only after a full four-phase cycle. src_req[i] high in IDLE with src_ack[i]=0 is a new request.
- Grant: at most one per cycle, only when fifo_level < DEPTH.
  - A pop in the same cycle does not free a slot for that cycle's grant.
- Round-robin: search starts at last granted channel + 1, with wrap-around. After reset, last granted = NUM_CH-1, so ch0 has first priority.
- Fixed priority: lowest eligible index wins. Starvation of higher indices is permitted.
- FIFO:
  - Show-ahead. dst_req = (fifo_level != 0).
  - Pop occurs when dst_req & dst_ack. dst_ack while dst_req=0 is ignored.
  - Simultaneous push and pop: level unchanged, order preserved.
  - Read and write pointers are CLOG2(DEPTH) bits and wrap naturally.
- dst_cmd/dst_ch are forced to 0 while dst_req=0.
- Protocol violation (src_req[i] dropped before ack in IDLE): channel simply not eligible; no capture.

## Timing
- Reset (rst=1 at an edge): all channels IDLE, src_ack=0, FIFO empty, fifo_level=0, dst_req=0, dst_cmd=0, dst_ch=0, RR pointer reset.
- Reset mid-operation:
  - Queued commands are discarded.
  - Asserted acks drop the cycle after reset.
  - A src_req still high after rst releases is captured again as a new request.
- Latency (empty FIFO, channel uncontested): src_req[i] rises before edge t and is granted at t. At t+1, src_ack[i]=1, dst_req=1, dst_cmd = captured value, fifo_level=1.
- src_req[i] falls before edge t → src_ack[i]=0 after edge t. The earliest re-request is granted at edge t+1.
- Pop at edge t: the next entry is presented (or dst_req=0) after t.
- Throughput: one grant and one pop per cycle sustained.
- fifo_level updates on the same edge as push/pop.

## Test plan
- Reset, then ch2 alone sends 16'hA5A5 → one cycle later src_ack[2]=1, dst_req=1, dst_cmd=16'hA5A5, dst_ch=2, fifo_level=1. src_ack[2] holds until src_req[2] falls, then clears next cycle.
- Round-robin: all 4 channels request continuously (four-phase each), dst_ack=1 → grant order 0,1,2,3,0,… with no channel granted twice before the others.
- PRIO_MODE=1, ch1 and ch3 request together → ch1 granted first. ch3 granted only after ch1 idles or completes, once no lower index is requesting.
- Full: dst_ack=0, 9 channel-requests with DEPTH=8 → fifo_level stops at 8 and the 9th src_ack stays 0. One pop → 9th granted the following cycle. Output order equals grant order.
- Simultaneous push/pop at fifo_level=3 → level stays 3 and the head advances.
- Assert rst with fifo_level=5 and src_ack[0]=1 → after the edge, level=0, dst_req=0, src_ack=0. src_req[0] still high → re-captured one cycle after rst release.

Source files
------------

// File: rtl/cmd_mux_queue.sv
// cmd_mux_queue: gathers commands from NUM_CH four-phase req/ack sources, arbitrates
// one per cycle (round-robin or fixed priority) into a show-ahead FIFO tagged with the
// source channel, and presents the FIFO head to a single downstream consumer.
module cmd_mux_queue #(
  parameter int CMD_WIDTH = 16,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter int PRIO_MODE = 0,
  localparam int CH_W     = $clog2(NUM_CH),
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*CMD_WIDTH-1:0] src_cmd,
  input  logic [NUM_CH-1:0]           src_req,
  output logic [NUM_CH-1:0]           src_ack,
  output logic [CMD_WIDTH-1:0]        dst_cmd,
  output logic [CH_W-1:0]             dst_ch,
  output logic                        dst_req,
  input  logic                        dst_ack,
  output logic [LVL_W-1:0]            fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, ACK} ch_state_t;

  ch_state_t            state [NUM_CH];
  logic [NUM_CH-1:0]    eligible;
  logic [CMD_WIDTH-1:0] src_slice [NUM_CH];
  logic                 gnt_valid;
  logic [CH_W-1:0]      gnt_idx;
  logic [CH_W-1:0]      cand;
  logic [CH_W-1:0]      last_gnt;
  logic [CMD_WIDTH-1:0] mem_cmd [DEPTH];
  logic [CH_W-1:0]      mem_ch [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 pop;

  // A channel competes only while idle with its request raised; also unpack commands.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i]  = (state[i] == IDLE) && src_req[i];
      src_slice[i] = src_cmd[i*CMD_WIDTH +: CMD_WIDTH];
    end
  end

  // Pick one winner; scanning from lowest to highest priority lets the last hit win.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (fifo_level < FULL_LEVEL) begin
      for (int k = NUM_CH; k >= 1; k--) begin
        if (PRIO_MODE != 0) cand = CH_W'(k - 1);
        else                cand = CH_W'((int'(last_gnt) + k) % NUM_CH);
        if (eligible[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  assign dst_req = (fifo_level != '0);
  assign pop     = dst_req && dst_ack;
  assign dst_cmd = dst_req ? mem_cmd[rd_ptr] : '0;
  assign dst_ch  = dst_req ? mem_ch[rd_ptr]  : '0;

  // Per-channel handshake FSM: grant raises ack, ack holds until the source drops req.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        state[i]   <= IDLE;
        src_ack[i] <= 1'b0;
      end else begin
        case (state[i])
          IDLE: if (gnt_valid && (gnt_idx == CH_W'(i))) begin
            state[i]   <= ACK;
            src_ack[i] <= 1'b1;
          end
          ACK: if (!src_req[i]) begin
            state[i]   <= IDLE;
            src_ack[i] <= 1'b0;
          end
          default: begin
            state[i]   <= IDLE;
            src_ack[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO storage needs no reset since outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (gnt_valid && !rst) begin
      mem_cmd[wr_ptr] <= src_slice[gnt_idx];
      mem_ch[wr_ptr]  <= gnt_idx;
    end
  end

  // Pointers, occupancy and round-robin history; a same-cycle push and pop cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= LAST_CH;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (gnt_valid) begin
        last_gnt <= gnt_idx;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({gnt_valid, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_mux_queue.sv
// tb_cmd_mux_queue: directed checks of a round-robin and a fixed-priority instance.
module tb_cmd_mux_queue;

  localparam int CW  = 16;
  localparam int NC  = 4;
  localparam int DP  = 8;
  localparam int LW  = $clog2(DP + 1);
  localparam int CHW = $clog2(NC);

  logic           clk = 1'b0;
  logic           rst;
  logic [NC*CW-1:0] src_cmd;
  logic [NC-1:0]  src_req;
  logic           dst_ack;

  logic [NC-1:0]  ack_rr, ack_fp;
  logic [CW-1:0]  cmd_rr, cmd_fp;
  logic [CHW-1:0] ch_rr, ch_fp;
  logic           req_rr, req_fp;
  logic [LW-1:0]  lvl_rr, lvl_fp;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] ch_cmd [NC];

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        dack;
    logic [3:0]  exp_ack;
    logic        exp_req;
    logic [15:0] exp_cmd;
    logic [1:0]  exp_ch;
    logic [3:0]  exp_lvl;
  } vec_t;

  vec_t vecs [12];

  // Free-running clock.
  always #5 clk = ~clk;

  cmd_mux_queue #(.CMD_WIDTH(CW), .NUM_CH(NC), .DEPTH(DP), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst), .src_cmd(src_cmd), .src_req(src_req), .src_ack(ack_rr),
    .dst_cmd(cmd_rr), .dst_ch(ch_rr), .dst_req(req_rr), .dst_ack(dst_ack),
    .fifo_level(lvl_rr)
  );

  cmd_mux_queue #(.CMD_WIDTH(CW), .NUM_CH(NC), .DEPTH(DP), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .src_cmd(src_cmd), .src_req(src_req), .src_ack(ack_fp),
    .dst_cmd(cmd_fp), .dst_ch(ch_fp), .dst_req(req_fp), .dst_ack(dst_ack),
    .fifo_level(lvl_fp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setCmds();
    for (int i = 0; i < NC; i++) src_cmd[i*CW +: CW] = ch_cmd[i];
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] req, input logic dack);
    rst     = r;
    src_req = req;
    dst_ack = dack;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRr(input string tag, input logic [3:0] ack, input logic dreq,
                         input logic [15:0] cmd, input logic [1:0] ch, input logic [3:0] lvl);
    checkOutput({tag, " src_ack"}, 64'(ack_rr), 64'(ack));
    checkOutput({tag, " dst_req"}, 64'(req_rr), 64'(dreq));
    checkOutput({tag, " dst_cmd"}, 64'(cmd_rr), 64'(cmd));
    checkOutput({tag, " dst_ch"},  64'(ch_rr),  64'(ch));
    checkOutput({tag, " level"},   64'(lvl_rr), 64'(lvl));
  endtask

  // Four-phase sources: raise req while ack low, drop it once ack is seen.
  task automatic reactiveCycles(input int n);
    for (int k = 0; k < n; k++) begin
      src_req = ~ack_rr;
      tick();
    end
  endtask

  // Directed sequence: vector table first, then multi-cycle corner cases.
  initial begin
    logic [1:0]  fill_ch  [8];
    logic [15:0] fill_cmd [8];
    logic [1:0]  fp_ch    [3];

    ch_cmd[0] = 16'h1000;
    ch_cmd[1] = 16'h1001;
    ch_cmd[2] = 16'hA5A5;
    ch_cmd[3] = 16'h1003;
    setCmds();
    applyStimulus(1'b1, 4'b0000, 1'b0);

    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0, 4'd0};
    vecs[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 16'hA5A5, 2'd2, 4'd1};
    vecs[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 16'hA5A5, 2'd2, 4'd1};
    vecs[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'hA5A5, 2'd2, 4'd1};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 4'd0};
    vecs[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 16'h1000, 2'd0, 4'd1};
    vecs[6]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 4'd0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 4'd0};
    vecs[8]  = '{1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1, 16'h1001, 2'd1, 4'd1};
    vecs[9]  = '{1'b0, 4'b1010, 1'b0, 4'b1010, 1'b1, 16'h1001, 2'd1, 4'd2};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'h1003, 2'd3, 4'd1};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 4'd0};

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].req, vecs[v].dack);
      tick();
      checkRr($sformatf("vec%0d", v), vecs[v].exp_ack, vecs[v].exp_req,
              vecs[v].exp_cmd, vecs[v].exp_ch, vecs[v].exp_lvl);
    end

    // Round-robin with all channels cycling and consumer always ready.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    for (int k = 0; k < 12; k++) begin
      src_req = ~ack_rr;
      tick();
      checkOutput($sformatf("rr%0d dst_ch", k), 64'(ch_rr), 64'(k % 4));
      checkOutput($sformatf("rr%0d src_ack", k), 64'(ack_rr), 64'(4'b0001 << (k % 4)));
      checkOutput($sformatf("rr%0d level", k), 64'(lvl_rr), 64'd1);
    end

    // Fill to DEPTH with the consumer stalled; the ninth request must wait.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      src_req = ~ack_rr;
      tick();
      checkOutput($sformatf("fill%0d level", k), 64'(lvl_rr), 64'(k + 1));
    end
    reactiveCycles(2);
    checkOutput("full level", 64'(lvl_rr), 64'd8);
    checkOutput("full src_ack", 64'(ack_rr), 64'd0);
    ch_cmd[0] = 16'hBEEF;
    setCmds();
    dst_ack = 1'b1;
    src_req = ~ack_rr;
    tick();
    checkOutput("pop-no-grant level", 64'(lvl_rr), 64'd7);
    checkOutput("pop-no-grant src_ack", 64'(ack_rr), 64'd0);
    dst_ack = 1'b0;
    src_req = ~ack_rr;
    tick();
    checkOutput("ninth src_ack", 64'(ack_rr), 64'b0001);
    checkOutput("ninth level", 64'(lvl_rr), 64'd8);
    fill_ch  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    fill_cmd = '{16'h1001, 16'hA5A5, 16'h1003, 16'h1000,
                 16'h1001, 16'hA5A5, 16'h1003, 16'hBEEF};
    applyStimulus(1'b0, 4'b0000, 1'b1);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("drain%0d dst_ch", j), 64'(ch_rr), 64'(fill_ch[j]));
      checkOutput($sformatf("drain%0d dst_cmd", j), 64'(cmd_rr), 64'(fill_cmd[j]));
      checkOutput($sformatf("drain%0d level", j), 64'(lvl_rr), 64'(8 - j));
      tick();
    end
    checkOutput("drained dst_req", 64'(req_rr), 64'd0);
    ch_cmd[0] = 16'h1000;
    setCmds();

    // Simultaneous push and pop at level 3.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b0);
    tick();
    src_req = 4'b0010;
    tick();
    src_req = 4'b0100;
    tick();
    checkRr("lvl3", 4'b0100, 1'b1, 16'h1000, 2'd0, 4'd3);
    applyStimulus(1'b0, 4'b1000, 1'b1);
    tick();
    checkRr("pushpop", 4'b1000, 1'b1, 16'h1001, 2'd1, 4'd3);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    tick();
    checkRr("pop-after", 4'b0000, 1'b1, 16'hA5A5, 2'd2, 4'd2);

    // Fixed priority: lowest idle requester wins, ch3 only once lower ones go quiet.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b1010, 1'b0);
    tick();
    checkOutput("fp1 src_ack", 64'(ack_fp), 64'b0010);
    checkOutput("fp1 dst_ch", 64'(ch_fp), 64'd1);
    checkOutput("fp1 dst_cmd", 64'(cmd_fp), 64'h1001);
    src_req = 4'b1011;
    tick();
    checkOutput("fp2 src_ack", 64'(ack_fp), 64'b0011);
    checkOutput("fp2 level", 64'(lvl_fp), 64'd2);
    src_req = 4'b1000;
    tick();
    checkOutput("fp3 src_ack", 64'(ack_fp), 64'b1000);
    checkOutput("fp3 level", 64'(lvl_fp), 64'd3);
    fp_ch = '{2'd1, 2'd0, 2'd3};
    applyStimulus(1'b0, 4'b0000, 1'b1);
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("fp drain%0d dst_ch", j), 64'(ch_fp), 64'(fp_ch[j]));
      tick();
    end
    checkOutput("fp drained level", 64'(lvl_fp), 64'd0);

    // Reset in the middle of traffic, with ch0 still requesting afterwards.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    reactiveCycles(5);
    checkRr("pre-rst", 4'b0001, 1'b1, 16'h1000, 2'd0, 4'd5);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    tick();
    checkRr("mid-rst", 4'b0000, 1'b0, 16'h0000, 2'd0, 4'd0);
    applyStimulus(1'b0, 4'b0001, 1'b0);
    tick();
    checkRr("recapture", 4'b0001, 1'b1, 16'h1000, 2'd0, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
